bit_serial_alu_ctrl: RTL and testbench
======================================

# bit_serial_alu_ctrl

Sequencer for the 1-bit ALU datapath: the AND/OR/XOR/adder/subtractor cells and the 3-bit result multiplexer. It accepts a WIDTH-bit operation request and streams operand bits LSB-first through the 1-bit datapath, one bit per cycle. It also carries the carry/borrow between bit slices and reassembles the WIDTH-bit result. It sits between the top-level I/O and the datapath, and owns the datapath's function select.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- clk_i  input  1  clock, all state on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  request strobe, sampled in IDLE and DONE only.
- op_i  input  `MUX_WIDTH  operation code: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB.
- a_i  input  WIDTH  operand A, sampled with start_i.
- b_i  input  WIDTH  operand B, sampled with start_i.
- busy_o  output  1  high while bits are being streamed.
- done_o  output  1  one-cycle pulse when result_o/carry_o become valid.
- result_o  output  WIDTH  assembled result, held until the next accepted start.
- carry_o  output  1  final carry (ADD) or borrow (SUB); 0 for logic ops.
- f_o  output  `MUX_WIDTH  function select to the datapath multiplexer.
- a_bit_o  output  1  current A bit to the datapath.
- b_bit_o  output  1  current B bit to the datapath.
- carry_bit_o  output  1  carry/borrow-in to the adder/subtractor cells.
- result_bit_i  input  1  multiplexer output, combinational from the bit outputs.
- carry_bit_i  input  1  carry-out (ADD) or borrow-out (SUB) of the current slice.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE / DONE + start_i**:
  - Load a_i and b_i into shift registers.
  - Latch op_i into the op register. Codes 101–111 are latched as 000 (AND).
  - Clear the carry register and bit counter → SHIFT.
- **SHIFT**, each cycle:
  - a_bit_o = A_sh[0], b_bit_o = B_sh[0], carry_bit_o = carry register, f_o = op register.
  - At the clock edge: shift result_bit_i into result shift register MSB (right shift).
  - Carry register ← carry_bit_i when op is ADD/SUB, else ← 0.
  - Shift A_sh and B_sh right; counter + 1.
  - When the counter reaches WIDTH−1 → DONE.
- **DONE**:
  - done_o = 1 for exactly one cycle.
  - result_o ← result shift register; carry_o ← carry register.
  - No start_i → IDLE. start_i → SHIFT (back-to-back op).
- start_i is ignored while in SHIFT; the in-flight operation is unaffected.
- Arithmetic is modulo 2^WIDTH.
  - SUB computes A − B; borrow-in of bit 0 is 0.
  - carry_o = 1 on unsigned overflow (ADD) or A < B (SUB).
- Counter width is $clog2(WIDTH); no wrap is reachable.
- result_o and carry_o update only on entry to DONE; they are stable otherwise.
- a_bit_o, b_bit_o and carry_bit_o are 0 outside SHIFT. f_o holds the last op.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT): state IDLE and the operation is aborted.
  - Outputs: busy_o = 0, done_o = 0, result_o = 0, carry_o = 0, f_o = 000.
  - a_bit_o = 0, b_bit_o = 0, carry_bit_o = 0.
- start_i is accepted at edge E0. SHIFT occupies the cycles after edges E0..E(WIDTH−1).
- DONE, with done_o high and result_o valid, is entered at edge E(WIDTH): latency WIDTH+1 edges.
- busy_o is high exactly WIDTH cycles per operation. done_o never overlaps busy_o.
- Throughput: one op per WIDTH+1 cycles with start_i held high.
- The datapath is combinational within one cycle; there is no pipeline stage between f_o/bit outputs and result_bit_i/carry_bit_i.

## Structure
- Shared defines/package:
  - `MUX_WIDTH (3).
  - The five operation code constants, identical to the multiplexer's parameter values.
  - FSM state encoding.
- One sub-module is natural: piso_shift_reg (WIDTH-bit parallel-load, shift-right, serial-out). It is instantiated twice, for A and B.
- Result assembly, counter and FSM stay in bit_serial_alu_ctrl.
- The top level instantiates this block plus the 1-bit datapath cells and the multiplexer.

## Test plan
- ADD 8'h5A + 8'h33 → done_o at edge 9 after start, result_o = 8'h8D, carry_o = 0; busy_o high exactly 8 cycles.
- ADD 8'hFF + 8'h01 → result_o = 8'h00, carry_o = 1.
- SUB 8'h10 − 8'h01 → 8'h0F, carry_o = 0. SUB 8'h00 − 8'h01 → 8'hFF, carry_o = 1.
- XOR 8'hF0 ^ 8'hAA → 8'h5A, carry_o = 0. Op 3'b111 with 8'hF0, 8'hAA → AND result 8'hA0, f_o = 000 during SHIFT.
- Start held high for ADD 8'h01 + 8'h01, with new inputs for OR 8'h0F | 8'hF0 applied during busy: the first op returns 8'h02, the start during busy is ignored, and the op accepted in DONE returns 8'hFF.
- Assert rst_ni low at SHIFT cycle 4: all outputs 0 immediately and state IDLE. A following ADD 8'h03 + 8'h04 returns 8'h07.

Source files
------------

// File: rtl/bit_serial_alu_ctrl_pkg.sv
// Shared constants for the bit-serial ALU sequencer: mux width, operation
// codes matching the datapath multiplexer, and the FSM state encoding.
package bit_serial_alu_ctrl_pkg;

  localparam int MUX_WIDTH = 3;

  localparam logic [MUX_WIDTH-1:0] OP_AND = 3'b000;
  localparam logic [MUX_WIDTH-1:0] OP_OR  = 3'b001;
  localparam logic [MUX_WIDTH-1:0] OP_XOR = 3'b010;
  localparam logic [MUX_WIDTH-1:0] OP_ADD = 3'b011;
  localparam logic [MUX_WIDTH-1:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Unassigned codes fall back to AND so the mux never sees them.
  function automatic logic [MUX_WIDTH-1:0] legal_op(input logic [MUX_WIDTH-1:0] op);
    return (op > OP_SUB) ? OP_AND : op;
  endfunction

  function automatic logic is_arith(input logic [MUX_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl_piso.sv
// Parallel-load, shift-right, serial-out register feeding one operand
// LSB-first into the 1-bit datapath.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign bit_o = data_q[0];

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer for the 1-bit ALU datapath: streams operands LSB-first, carries
// the carry/borrow between slices and reassembles the WIDTH-bit result.
module bit_serial_alu_ctrl
  import bit_serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [MUX_WIDTH-1:0] op_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH-1:0]     result_o,
  output logic                 carry_o,
  output logic [MUX_WIDTH-1:0] f_o,
  output logic                 a_bit_o,
  output logic                 b_bit_o,
  output logic                 carry_bit_o,
  input  logic                 result_bit_i,
  input  logic                 carry_bit_i
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [MUX_WIDTH-1:0] op_q;
  logic                 carry_q;
  logic [WIDTH-2:0]     res_sh_q;
  logic [WIDTH-1:0]     result_q;
  logic                 carry_out_q;

  logic             load;
  logic             shifting;
  logic             last_bit;
  logic             carry_nxt;
  logic             a_sh_bit;
  logic             b_sh_bit;
  logic [WIDTH-1:0] res_shifted;

  assign load        = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign shifting    = (state_q == ST_SHIFT);
  assign last_bit    = shifting && (cnt_q == LAST_CNT);
  assign carry_nxt   = is_arith(op_q) ? carry_bit_i : 1'b0;
  // On the final slice this is the complete result, including the current bit.
  assign res_shifted = {result_bit_i, res_sh_q};

  piso_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk_i  (clk_i),
    .load_i (load),
    .shift_i(shifting),
    .data_i (a_i),
    .bit_o  (a_sh_bit)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk_i  (clk_i),
    .load_i (load),
    .shift_i(shifting),
    .data_i (b_i),
    .bit_o  (b_sh_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = start_i ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = shifting;
    done_o      = (state_q == ST_DONE);
    a_bit_o     = shifting ? a_sh_bit : 1'b0;
    b_bit_o     = shifting ? b_sh_bit : 1'b0;
    carry_bit_o = shifting ? carry_q  : 1'b0;
    f_o         = op_q;
    result_o    = result_q;
    carry_o     = carry_out_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      op_q        <= OP_AND;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= '0;
      op_q    <= legal_op(op_i);
      carry_q <= 1'b0;
    end else if (shifting) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      carry_q <= carry_nxt;
      if (last_bit) begin
        result_q    <= res_shifted;
        carry_out_q <= carry_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (shifting) begin
      res_sh_q <= res_shifted[WIDTH-1:1];
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed bench for bit_serial_alu_ctrl with a behavioural 1-bit datapath
// closing the loop between the bit outputs and result/carry inputs.
module tb_bit_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, carry, a_bit, b_bit, cin, rbit, cbit;
  logic [7:0] result;
  logic [2:0] f;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result), .carry_o(carry), .f_o(f),
    .a_bit_o(a_bit), .b_bit_o(b_bit), .carry_bit_o(cin),
    .result_bit_i(rbit), .carry_bit_i(cbit)
  );

  // Behavioural 1-bit datapath: logic cells, full adder, full subtractor, mux.
  always_comb begin
    rbit = 1'b0;
    cbit = 1'b0;
    case (f)
      3'b000: rbit = a_bit & b_bit;
      3'b001: rbit = a_bit | b_bit;
      3'b010: rbit = a_bit ^ b_bit;
      3'b011: begin
        rbit = a_bit ^ b_bit ^ cin;
        cbit = (a_bit & b_bit) | (a_bit & cin) | (b_bit & cin);
      end
      3'b100: begin
        rbit = a_bit ^ b_bit ^ cin;
        cbit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & cin);
      end
      default: ;
    endcase
  end

  task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        output int done_edge, output int busy_cyc, output int overlap,
                        output logic [2:0] f_shift, output logic done_next);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    done_edge = 0; busy_cyc = 0; overlap = 0; f_shift = 3'bxxx;
    for (int e = 1; e <= 30 && done_edge == 0; e++) begin
      @(posedge clk); #1;
      if (e == 1) start = 1'b0;
      if (busy) begin
        busy_cyc++;
        if (busy_cyc == 1) f_shift = f;
      end
      if (busy && done) overlap++;
      if (done) done_edge = e;
    end
    @(posedge clk); #1;
    done_next = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if ({busy, done, carry, a_bit, b_bit, cin} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, carry, a_bit, b_bit, cin});
    end else n_pass++;
    n_total++;
    if (result !== 8'h00) $display("FAIL reset_result: got %h expected 00", result);
    else n_pass++;
    n_total++;
    if (f !== 3'b000) $display("FAIL reset_f: got %b expected 000", f);
    else n_pass++;
    n_total++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int de, bc, ov; logic [2:0] fs; logic dn;
    run_op(3'b011, 8'h5A, 8'h33, de, bc, ov, fs, dn);
    if (result !== 8'h8D) $display("FAIL add_result: got %h expected 8d", result);
    else n_pass++;
    n_total++;
    if (carry !== 1'b0) $display("FAIL add_carry: got %b expected 0", carry);
    else n_pass++;
    n_total++;
    if (de != 9) $display("FAIL add_latency: got edge %0d expected 9", de);
    else n_pass++;
    n_total++;
    if (bc != 8) $display("FAIL add_busy_cycles: got %0d expected 8", bc);
    else n_pass++;
    n_total++;
    if (ov != 0) $display("FAIL add_overlap: got %0d expected 0", ov);
    else n_pass++;
    n_total++;
    if (dn !== 1'b0) $display("FAIL add_done_pulse: got %b expected 0", dn);
    else n_pass++;
    n_total++;
    if (fs !== 3'b011) $display("FAIL add_f: got %b expected 011", fs);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_add_overflow();
    int de, bc, ov; logic [2:0] fs; logic dn;
    run_op(3'b011, 8'hFF, 8'h01, de, bc, ov, fs, dn);
    if ({carry, result} !== 9'h100) $display("FAIL add_ovf: got %b/%h expected 1/00", carry, result);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_sub();
    int de, bc, ov; logic [2:0] fs; logic dn;
    run_op(3'b100, 8'h10, 8'h01, de, bc, ov, fs, dn);
    if ({carry, result} !== 9'h00F) $display("FAIL sub_plain: got %b/%h expected 0/0f", carry, result);
    else n_pass++;
    n_total++;
    run_op(3'b100, 8'h00, 8'h01, de, bc, ov, fs, dn);
    if ({carry, result} !== 9'h1FF) $display("FAIL sub_borrow: got %b/%h expected 1/ff", carry, result);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_xor();
    int de, bc, ov; logic [2:0] fs; logic dn;
    run_op(3'b010, 8'hF0, 8'hAA, de, bc, ov, fs, dn);
    if ({carry, result} !== 9'h05A) $display("FAIL xor: got %b/%h expected 0/5a", carry, result);
    else n_pass++;
    n_total++;
    repeat (3) @(posedge clk);
    #1;
    if ({busy, done, result} !== 10'h05A) $display("FAIL xor_hold: got %b%b/%h expected 00/5a", busy, done, result);
    else n_pass++;
    n_total++;
    if ({a_bit, b_bit, cin} !== 3'b000) $display("FAIL idle_bits: got %b expected 000", {a_bit, b_bit, cin});
    else n_pass++;
    n_total++;
    if (f !== 3'b010) $display("FAIL f_hold: got %b expected 010", f);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_illegal_op();
    int de, bc, ov; logic [2:0] fs; logic dn;
    run_op(3'b111, 8'hF0, 8'hAA, de, bc, ov, fs, dn);
    if ({carry, result} !== 9'h0A0) $display("FAIL illegal_result: got %b/%h expected 0/a0", carry, result);
    else n_pass++;
    n_total++;
    if (fs !== 3'b000) $display("FAIL illegal_f: got %b expected 000", fs);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = 0; d2 = 0;
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    op = 3'b001; a = 8'h0F; b = 8'hF0;
    for (int e = 2; e <= 30 && d1 == 0; e++) begin
      @(posedge clk); #1;
      if (done) d1 = e;
    end
    if (d1 != 9) $display("FAIL b2b_first_latency: got edge %0d expected 9", d1);
    else n_pass++;
    n_total++;
    if ({carry, result} !== 9'h002) $display("FAIL b2b_first: got %b/%h expected 0/02", carry, result);
    else n_pass++;
    n_total++;
    @(posedge clk); #1;
    start = 1'b0;
    if ({busy, done} !== 2'b10) $display("FAIL b2b_restart: got %b expected 10", {busy, done});
    else n_pass++;
    n_total++;
    for (int e = d1 + 2; e <= 40 && d2 == 0; e++) begin
      @(posedge clk); #1;
      if (done) d2 = e;
    end
    if (d2 - d1 != 9) $display("FAIL b2b_period: got %0d expected 9", d2 - d1);
    else n_pass++;
    n_total++;
    if ({carry, result} !== 9'h0FF) $display("FAIL b2b_second: got %b/%h expected 0/ff", carry, result);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_mid_shift();
    int de, bc, ov; logic [2:0] fs; logic dn;
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if ({busy, a_bit} !== 2'b11) $display("FAIL mid_shift_pre: got %b expected 11", {busy, a_bit});
    else n_pass++;
    n_total++;
    rst_n = 1'b0;
    #1;
    if ({busy, done, carry, a_bit, b_bit, cin, f, result} !== 17'h0) begin
      $display("FAIL async_reset: got %b %b %h expected all zero",
               {busy, done, carry, a_bit, b_bit, cin}, f, result);
    end else n_pass++;
    n_total++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if ({busy, done} !== 2'b00) $display("FAIL reset_idle: got %b expected 00", {busy, done});
    else n_pass++;
    n_total++;
    run_op(3'b011, 8'h03, 8'h04, de, bc, ov, fs, dn);
    if ({carry, result} !== 9'h007) $display("FAIL post_reset_add: got %b/%h expected 0/07", carry, result);
    else n_pass++;
    n_total++;
    if (de != 9) $display("FAIL post_reset_latency: got edge %0d expected 9", de);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_overflow();
    test_sub();
    test_xor();
    test_illegal_op();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
